cpc_rom_bootloader: RTL
=======================

# cpc_rom_bootloader

Receives the CPC system ROM image (OS, BASIC, AMSDOS) from the control module as 32-bit words over a four-phase req/ack handshake. Splits each word into bytes and writes them into SRAM through the shared ROM-write port, one byte per granted SRAM write slot. Sits between the control module's `host_bootdata` interface and the machine's SRAM address/data mux. Asserts `host_rom_initialised` once the full image is stored, which releases the CPU from boot hold.

## Interface

Parameters:
- `ADDR_W`, 19: SRAM byte-address width.
- `BASE_ADDR`, 19'h00000: SRAM address of the first ROM byte.
- `ROM_BYTES`, 49152: image length in bytes; must be a nonzero multiple of 4.

Ports:
- `ck16`  in  1  system clock, 16 MHz.
- `pown_reset_n`  in  1  reset, asynchronous, active-low.
- `host_bootdata`  in  32  word from the host; stable while `host_bootdata_req`=1.
- `host_bootdata_req`  in  1  host request; a level, four-phase.
- `host_bootdata_ack`  out  1  acknowledge; a level, four-phase.
- `wr_slot`  in  1  SRAM write grant for this cycle from the memory arbiter.
- `romwrite_addr`  out  ADDR_W  SRAM byte address.
- `romwrite_data`  out  8  SRAM byte data.
- `romwrite_wr`  out  1  write strobe; SRAM latches the byte on a `ck16` edge where this is 1.
- `host_rom_initialised`  out  1  full image written; sticky until reset.
- `rom_checksum`  out  8  running additive checksum (see Configuration).

## Operation

- States: IDLE, WR0, WR1, WR2, WR3, ACK, DONE.
- **IDLE**
  - `host_bootdata_req`=1 → latch `host_bootdata` into the word register, go to WR0.
  - `host_bootdata_req`=0 → stay.
- **WRn** (n=0..3)
  - `romwrite_data` = word[8n+7:8n]; little-endian, byte 0 at the lowest address.
  - `romwrite_addr` = `BASE_ADDR` + byte count.
  - `romwrite_wr` = 1 exactly when `wr_slot`=1 (combinational AND of state and `wr_slot`).
  - On a slot edge: byte count +1 and advance to the next state. WR3 advances to ACK.
  - `wr_slot`=0 → hold state; address and data stay stable.
- **ACK**
  - `host_bootdata_ack`=1, registered.
  - Wait for `host_bootdata_req`=0, then drop ack. Go to DONE if byte count = `ROM_BYTES`, else IDLE.
- **DONE**
  - `host_rom_initialised`=1.
  - A further req is still acknowledged so the host never hangs: ack rises the edge after req=1 and falls the edge after req=0.
  - No SRAM writes; count and address frozen.
- Byte count is `ADDR_W` bits wide and never wraps: DONE is entered at exactly `ROM_BYTES`.
- Reset values:
  - state IDLE, byte count 0.
  - `host_bootdata_ack`=0, `romwrite_wr`=0, `host_rom_initialised`=0, `rom_checksum`=0.
  - `romwrite_addr`=`BASE_ADDR`, `romwrite_data`=0.
- Reset mid-word (any WRn or ACK): the partial word is discarded and the count returns to 0. The host restarts from byte 0.

## Timing

- Edge E0 samples req=1 in IDLE. With `wr_slot` held at 1:
  - the four write strobes are high in cycles E0–E1, E1–E2, E2–E3 and E3–E4;
  - ack rises at E5.
- Each cycle with `wr_slot`=0 in WRn adds one cycle of latency.
- Ack falls on the first edge that samples req=0 in ACK.
- For the final word, `host_rom_initialised` rises on that same edge.
- Host rule: do not raise req again until ack=0. A req still high in IDLE is treated as a new word. The host must not change `host_bootdata` while req=1.
- Minimum time per word: 6 cycles (4 writes, ACK entry, ack fall), plus host turnaround.

## Configuration

- `CPC_BOOTLOADER_CHECKSUM_EN` defined:
  - `rom_checksum` = 8-bit modulo-256 sum of every byte written, updated on each write edge.
  - Frozen in DONE; cleared by reset.
- Undefined: `rom_checksum` is tied to 8'h00 and no adder is built.

## Test plan

- **Single word, wr_slot=1:** word 32'h44332211, req held until ack.
  - Writes 11,22,33,44 to addresses 0,1,2,3 on four consecutive edges.
  - Ack rises at E5 and falls one edge after req drops.
- **Slot stalls:** `wr_slot` alternating 0/1 starting at 0.
  - `romwrite_wr` asserts only in slot cycles; address and data hold during stalls.
  - Ack is delayed by 4 cycles versus the previous case.
- **Full image:** `ROM_BYTES`=16, four words.
  - `host_rom_initialised` rises on the ack-fall edge of word 4 and not earlier.
  - A fifth req is acked with no `romwrite_wr` pulse.
- **Reset mid-word:** `pown_reset_n` pulsed low while in WR2.
  - All outputs immediately return to reset values.
  - The next word writes to `BASE_ADDR`.
- **Checksum with macro:** bytes 01..10 (hex) over 4 words.
  - `rom_checksum`=8'h88 after the last write.
  - Without the macro it stays 8'h00.

Source files
------------

// File: rtl/cpc_rom_bootloader_if.sv
// Bundle between the control module's boot-data port, the SRAM write arbiter and
// the ROM bootloader.
// Boot-data handshake: a four-phase req/ack exchange where req and ack are both
// levels. The host raises req with host_bootdata stable. The loader raises ack
// once the word is stored. The host then drops req, and the loader drops ack.
// The host may raise req again only after it sees ack=0.
interface cpc_rom_bootloader_if #(
    parameter int ADDR_W = 19
);
    logic [31:0]       host_bootdata;
    logic              host_bootdata_req;
    logic              host_bootdata_ack;
    logic              wr_slot;
    logic [ADDR_W-1:0] romwrite_addr;
    logic [7:0]        romwrite_data;
    logic              romwrite_wr;
    logic              host_rom_initialised;
    logic [7:0]        rom_checksum;

    modport master (
        output host_bootdata, host_bootdata_req, wr_slot,
        input  host_bootdata_ack, romwrite_addr, romwrite_data, romwrite_wr,
        input  host_rom_initialised, rom_checksum
    );

    modport slave (
        input  host_bootdata, host_bootdata_req, wr_slot,
        output host_bootdata_ack, romwrite_addr, romwrite_data, romwrite_wr,
        output host_rom_initialised, rom_checksum
    );
endinterface

// File: rtl/cpc_rom_bootloader.sv
// Streams the CPC system ROM image from host words into SRAM, one byte per granted
// write slot. Optional running checksum is enabled by CPC_BOOTLOADER_CHECKSUM_EN.
module cpc_rom_bootloader #(
    parameter int                ADDR_W    = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ROM_BYTES = 49152
) (
    input  logic                   ck16,
    input  logic                   pown_reset_n,
    cpc_rom_bootloader_if.slave    bus,
    output logic [2:0]             fsm_state
);
    typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3, ACK, DONE} state_t;

    localparam logic [ADDR_W-1:0] END_COUNT = ADDR_W'(ROM_BYTES);

    state_t            state;
    logic [31:0]       word;
    logic [ADDR_W-1:0] count;
    logic              ack;
    logic              initialised;
    logic              in_write;
    logic              write_edge;
    logic [7:0]        byte_sel;

    assign in_write   = (state == WR0) || (state == WR1) || (state == WR2) || (state == WR3);
    assign write_edge = in_write && bus.wr_slot;

    // Little-endian split: WR0 carries the lowest byte to the lowest address.
    always_comb begin
        byte_sel = 8'h00;
        case (state)
            WR0:     byte_sel = word[7:0];
            WR1:     byte_sel = word[15:8];
            WR2:     byte_sel = word[23:16];
            WR3:     byte_sel = word[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    assign bus.romwrite_addr        = BASE_ADDR + count;
    assign bus.romwrite_data        = byte_sel;
    assign bus.romwrite_wr          = write_edge;
    assign bus.host_bootdata_ack    = ack;
    assign bus.host_rom_initialised = initialised;
    assign fsm_state                = state;

    always_ff @(posedge ck16 or negedge pown_reset_n) begin
        if (!pown_reset_n) begin
            state       <= IDLE;
            word        <= '0;
            count       <= '0;
            ack         <= 1'b0;
            initialised <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.host_bootdata_req) begin
                        word  <= bus.host_bootdata;
                        state <= WR0;
                    end
                end
                WR0: if (bus.wr_slot) begin count <= count + 1'b1; state <= WR1; end
                WR1: if (bus.wr_slot) begin count <= count + 1'b1; state <= WR2; end
                WR2: if (bus.wr_slot) begin count <= count + 1'b1; state <= WR3; end
                WR3: if (bus.wr_slot) begin count <= count + 1'b1; state <= ACK; end
                ACK: begin
                    // Ack is raised one edge after entry, then held until req drops.
                    if (!ack) begin
                        ack <= 1'b1;
                    end else if (!bus.host_bootdata_req) begin
                        ack <= 1'b0;
                        if (count == END_COUNT) begin
                            state       <= DONE;
                            initialised <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: ack <= bus.host_bootdata_req;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPC_BOOTLOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge ck16 or negedge pown_reset_n) begin
        if (!pown_reset_n) begin
            sum <= 8'h00;
        end else if (write_edge) begin
            sum <= sum + byte_sel;
        end
    end

    assign bus.rom_checksum = sum;
`else
    assign bus.rom_checksum = 8'h00;
`endif
endmodule
